// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: time-multiplexed WIDTH-bit magnitude comparator.
// Walks the operands CHUNK bits per clock, MSB chunk first, and stops on the
// first differing chunk. Start/busy/done handshake; gt/eq/lt are held until
// the next completed compare.
// Build option: define SIGNED_CMP_EN to treat operands as two's complement.
module seq_mag_comparator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;

  // Select the chunk under comparison from the latched operands.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        chunk_a = a_q[i*CHUNK +: CHUNK];
        chunk_b = b_q[i*CHUNK +: CHUNK];
      end
    end
`ifdef SIGNED_CMP_EN
    // Inverting the sign bit maps two's complement order onto unsigned order.
    if (idx_q == IDX_TOP) begin
      chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
      chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
    end
`endif
  end

  // Next-state logic for the IDLE/RUN controller and result registers.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_TOP;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (chunk_a != chunk_b) begin
          gt_d    = (chunk_a > chunk_b);
          lt_d    = (chunk_a < chunk_b);
          eq_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (idx_q == '0) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Bench for seq_mag_comparator: an 8-bit/2-bit-chunk instance and a
// 2-bit/1-bit-chunk instance, each with a scoreboard of expected results and
// start-to-done latencies. Honours SIGNED_CMP_EN in its reference model.
module tb_seq_mag_comparator;

  typedef struct {
    logic [2:0]  res;     // {gt, eq, lt}
    int unsigned edge_n;  // cycle number of the accepting edge
    int unsigned lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start2;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;
  logic       busy8, done8, gt8, eq8, lt8;
  logic       busy2, done2, gt2, eq2, lt2;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned done8_count = 0;

  exp_t sb8[$];
  exp_t sb2[$];

  seq_mag_comparator #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8)
  );

  seq_mag_comparator #(.WIDTH(2), .CHUNK(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .gt(gt2), .eq(eq2), .lt(lt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Whole-operand reference compare, returns {gt, eq, lt}.
  function automatic logic [2:0] model_res(input int unsigned w, input logic [31:0] av,
                                           input logic [31:0] bv);
    int ai, bi;
    ai = int'(av);
    bi = int'(bv);
`ifdef SIGNED_CMP_EN
    if (av[w-1]) ai = ai - (1 << w);
    if (bv[w-1]) bi = bi - (1 << w);
`endif
    if (ai > bi) return 3'b100;
    if (ai == bi) return 3'b010;
    return 3'b001;
  endfunction

  // Position (from MSB, 1-based) of the first differing chunk; n if equal.
  function automatic int unsigned model_lat(input int unsigned w, input int unsigned c,
                                            input logic [31:0] av, input logic [31:0] bv);
    int unsigned n = w / c;
    logic [31:0] mask = (32'd1 << c) - 32'd1;
    for (int unsigned k = 1; k <= n; k++) begin
      if ((((av ^ bv) >> ((n - k) * c)) & mask) != 0) return k;
    end
    return n;
  endfunction

  // Scoreboard monitor, 8-bit instance.
  logic [2:0] held8 = 3'b000;
  logic       prev_done8 = 1'b0;
  exp_t       e8;
  always @(negedge clk) begin
    if (!rst_n) begin
      held8      = 3'b000;
      prev_done8 = 1'b0;
    end else begin
      if (prev_done8) check("done8_single_pulse", {31'd0, done8}, 32'd0);
      if (done8) begin
        done8_count++;
        if (sb8.size() == 0) begin
          check("done8_unexpected", 32'd1, 32'd0);
        end else begin
          e8 = sb8.pop_front();
          check("res8", {29'd0, gt8, eq8, lt8}, {29'd0, e8.res});
          check("lat8", cyc - e8.edge_n, e8.lat);
          check("busy8_low_at_done", {31'd0, busy8}, 32'd0);
          held8 = e8.res;
        end
      end else begin
        check("hold8", {29'd0, gt8, eq8, lt8}, {29'd0, held8});
      end
      prev_done8 = done8;
    end
  end

  // Scoreboard monitor, 2-bit instance.
  logic [2:0] held2 = 3'b000;
  logic       prev_done2 = 1'b0;
  exp_t       e2;
  always @(negedge clk) begin
    if (!rst_n) begin
      held2      = 3'b000;
      prev_done2 = 1'b0;
    end else begin
      if (prev_done2) check("done2_single_pulse", {31'd0, done2}, 32'd0);
      if (done2) begin
        if (sb2.size() == 0) begin
          check("done2_unexpected", 32'd1, 32'd0);
        end else begin
          e2 = sb2.pop_front();
          check("res2", {29'd0, gt2, eq2, lt2}, {29'd0, e2.res});
          check("lat2", cyc - e2.edge_n, e2.lat);
          held2 = e2.res;
        end
      end else begin
        check("hold2", {29'd0, gt2, eq2, lt2}, {29'd0, held2});
      end
      prev_done2 = done2;
    end
  end

  // Called at posedge+#1; raises start for one edge and scrambles operands after.
  task automatic drive_start(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                             input bit accept);
    exp_t e;
    if (sel == 1'b0) begin
      a8 = av; b8 = bv; start8 = 1'b1;
    end else begin
      a2 = av[1:0]; b2 = bv[1:0]; start2 = 1'b1;
    end
    if (accept) begin
      e.edge_n = cyc + 1;
      if (sel == 1'b0) begin
        e.res = model_res(8, {24'd0, av}, {24'd0, bv});
        e.lat = model_lat(8, 2, {24'd0, av}, {24'd0, bv});
        sb8.push_back(e);
      end else begin
        e.res = model_res(2, {30'd0, av[1:0]}, {30'd0, bv[1:0]});
        e.lat = model_lat(2, 1, {30'd0, av[1:0]}, {30'd0, bv[1:0]});
        sb2.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    start8 = 1'b0;
    start2 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    a2 = 2'($urandom);
    b2 = 2'($urandom);
    if (accept && e.lat > 1) begin
      if (sel == 1'b0) check("busy8_after_start", {31'd0, busy8}, 32'd1);
      else             check("busy2_after_start", {31'd0, busy2}, 32'd1);
    end
  endtask

  // Advance (posedge+#1 steps) until done is high, bounded.
  task automatic wait_done(input bit sel);
    for (int i = 0; i < 40; i++) begin
      if ((sel == 1'b0 && done8) || (sel == 1'b1 && done2)) return;
      @(posedge clk);
      #1;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int unsigned dc;
    rst_n = 1'b0;
    start8 = 1'b0; start2 = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0;
    idle_cycles(3);
    check("reset8_outputs", {27'd0, busy8, done8, gt8, eq8, lt8}, 32'd0);
    check("reset2_outputs", {27'd0, busy2, done2, gt2, eq2, lt2}, 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Equal operands: full NCHUNK walk.
    drive_start(1'b0, 8'hA5, 8'hA5, 1'b1);
    wait_done(1'b0);
    idle_cycles(2);

    // MSB chunk differs: one-cycle result, sign-sensitive.
    drive_start(1'b0, 8'h80, 8'h7F, 1'b1);
    wait_done(1'b0);
    idle_cycles(1);

    // Back-to-back: second start issued in the done cycle.
    drive_start(1'b0, 8'h12, 8'h13, 1'b1);
    wait_done(1'b0);
    drive_start(1'b0, 8'h40, 8'h13, 1'b1);
    wait_done(1'b0);
    idle_cycles(2);

    // Start while busy is ignored.
    drive_start(1'b0, 8'h00, 8'hFF, 1'b1);
    drive_start(1'b0, 8'hFF, 8'h00, 1'b0);
    idle_cycles(4);

    // Reset mid-operation.
    drive_start(1'b0, 8'h33, 8'h33, 1'b1);
    idle_cycles(1);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {27'd0, busy8, done8, gt8, eq8, lt8}, 32'd0);
    sb8.delete();
    idle_cycles(1);
    rst_n = 1'b1;
    dc = done8_count;
    idle_cycles(8);
    check("no_stale_done", done8_count, dc);

    // Randomised operands with random gaps, including back-to-back.
    for (int n = 0; n < 40; n++) begin
      drive_start(1'b0, 8'($urandom), 8'($urandom), 1'b1);
      wait_done(1'b0);
      idle_cycles($urandom_range(0, 2));
    end
    // Random equal and near-equal pairs to exercise the full walk.
    for (int n = 0; n < 10; n++) begin
      logic [7:0] r;
      r = 8'($urandom);
      drive_start(1'b0, r, r ^ (8'd1 << $urandom_range(0, 7)), 1'b1);
      wait_done(1'b0);
      drive_start(1'b0, r, r, 1'b1);
      wait_done(1'b0);
    end

    // Exhaustive 2-bit truth table on the narrow instance.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        drive_start(1'b1, 8'(i), 8'(j), 1'b1);
        wait_done(1'b1);
      end
    end
    idle_cycles(4);

    check("sb8_drained", sb8.size(), 32'd0);
    check("sb2_drained", sb2.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
